dp_hazard_ctrl: RTL

Pipeline hazard controller that drives the enable/clear side of the decode/execute pipeline register and the fetch and decode stage registers. It detects load-use hazards and taken branches, and generates the operand-forwarding selects for execute. It also runs a small FSM that holds a multi-cycle execute operation in E for a fixed number of cycles. It sits beside the datapath and consumes register indices and control bits from the D/E/M/W stages.

---
 rtl/dp_hazard_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dp_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush, operand forwarding,
// and a hold FSM that keeps a multi-cycle op in E.  IDLE: no op held | BUSY: op counting down in E.
module dp_hazard_ctrl #(
  parameter int IDX_W      = 3,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             ResetN,
  input  logic [IDX_W-1:0] RA1D,
  input  logic [IDX_W-1:0] RA2D,
  input  logic             UseAD,
  input  logic             UseBD,
  input  logic [IDX_W-1:0] RA1E,
  input  logic [IDX_W-1:0] RA2E,
  input  logic [IDX_W-1:0] WIndexE,
  input  logic [IDX_W-1:0] WIndexM,
  input  logic [IDX_W-1:0] WIndexW,
  input  logic             RegWE,
  input  logic             RegWM,
  input  logic             RegWW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             MulStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             EnIE,
  output logic             ClrIE,
  output logic             BubbleM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MulDoneE,
  output logic [CNT_W-1:0] StallCnt
);

  if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("dp_hazard_ctrl: MUL_CYCLES=%0d outside 2..15", MUL_CYCLES);
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_hold, w_done, w_ld_stall, w_br_flush;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: if (MulStartE) begin
          r_state <= BUSY;
          r_cnt   <= 4'(MUL_CYCLES - 1);
        end
        BUSY: if (r_cnt > 4'd1) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          // MulStartE is deliberately ignored here so the finishing op is not restarted
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN)
      r_stall_cnt <= '0;
    else if (StallD && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  // Everything is gated by ResetN so outputs sit at their idle values while reset is held
  assign w_hold = ResetN && (((r_state == IDLE) && MulStartE) ||
                             ((r_state == BUSY) && (r_cnt > 4'd1)));
  assign w_done = ResetN && (r_state == BUSY) && (r_cnt == 4'd1);
  assign w_ld_stall = ResetN && MemtoRegE && RegWE &&
                      ((UseAD && (RA1D == WIndexE)) || (UseBD && (RA2D == WIndexE)));
  assign w_br_flush = ResetN && BranchTakenE && !w_hold;

  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    EnIE    = 1'b1;
    ClrIE   = 1'b0;
    BubbleM = 1'b0;
    if (w_hold) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      EnIE    = 1'b0;
      BubbleM = 1'b1;
    end else if (w_br_flush) begin
      FlushD = 1'b1;
      ClrIE  = 1'b1;
    end else if (w_ld_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      ClrIE  = 1'b1;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (ResetN) begin
      if (RegWM && (WIndexM == RA1E))      ForwardAE = 2'b10;
      else if (RegWW && (WIndexW == RA1E)) ForwardAE = 2'b01;
      if (RegWM && (WIndexM == RA2E))      ForwardBE = 2'b10;
      else if (RegWW && (WIndexW == RA2E)) ForwardBE = 2'b01;
    end
  end

  assign MulDoneE = w_done;
  assign StallCnt = r_stall_cnt;

endmodule
